lcd_ctrl: RTL and testbench
===========================

// Module: lcd_ctrl
// PURPOSE
//  Character-LCD (HD44780-style, 8-bit bus, write-only) controller that main
//  instantiates to drive LCD_E/LCD_RS/LCD_RW/LCD_DATA. After reset it replays a
//  fixed four-command init sequence. It then accepts one byte at a time
//  (command or data) over a valid/ready handshake and generates the E strobe
//  with setup, hold and execution-wait timing counted in clk cycles.
// PARAMETERS
//  SETUP_CYC       1   cycles RS/DATA are stable with E low before the strobe (>=1)
//  E_HIGH_CYC      2   cycles LCD_E is held high (>=1)
//  HOLD_CYC        1   cycles E is low with RS/DATA still held, after the strobe (>=1)
//  CMD_WAIT_CYC    4   execution wait after a normal command or data write (>=1)
//  CLEAR_WAIT_CYC  16  execution wait after a clear/home command, RS=0 and DATA=0x01/0x02/0x03 (>=1)
// PORTS
//  clk        in   1  system clock, rising edge
//  resetn     in   1  asynchronous active-low reset
//  wr_valid   in   1  write request
//  wr_ready   out  1  controller idle and accepting; a transfer occurs when wr_valid & wr_ready
//  wr_rs      in   1  0 = command, 1 = data; sampled on acceptance
//  wr_data    in   8  byte to write; sampled on acceptance
//  init_done  out  1  init sequence complete; sticky until reset
//  LCD_E      out  1  enable strobe
//  LCD_RS     out  1  register select
//  LCD_RW     out  1  read/write; tied 0 (write only)
//  LCD_DATA   out  8  data bus
// BEHAVIOUR
//  - Reset: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, wr_ready=0, init_done=0,
//    state=INIT, init index=0. Asserting reset mid-transfer aborts immediately;
//    E drops asynchronously and init restarts after release.
//  - All outputs are registered (Moore). LCD_RW is constant 0.
//  - States: INIT -> SETUP -> EHI -> HOLD -> WAIT -> (INIT | IDLE).
//    INIT: loads init ROM[idx] with RS=0, then goes to SETUP on the next edge.
//    ROM = 0x38 (function set), 0x0C (display on), 0x01 (clear), 0x06 (entry mode).
//    SETUP holds SETUP_CYC cycles with E=0. EHI holds E_HIGH_CYC cycles with E=1.
//    HOLD holds HOLD_CYC cycles with E=0. WAIT holds W cycles with E=0.
//    W = CLEAR_WAIT_CYC if RS=0 and DATA[7:2]==0 and DATA!=0; otherwise W = CMD_WAIT_CYC.
//    WAIT exit: goes to INIT while idx<3 (idx++). Otherwise goes to IDLE and sets init_done.
//    IDLE: wr_ready=1. On an edge with wr_valid=1, latch wr_rs/wr_data into LCD_RS/LCD_DATA,
//    set wr_ready=0, and go to SETUP.
//  - Latency: an accept at edge k gives E rising at edge k+SETUP_CYC and falling at edge
//    k+SETUP_CYC+E_HIGH_CYC. wr_ready is high again from edge k+S+E+H+W.
//    With defaults this is 8 cycles for a normal write and 20 cycles for a clear.
//  - wr_ready is never 1 before init_done. wr_valid during init or busy is ignored
//    (not queued); the requester must hold valid until it is accepted.
//  - LCD_RS/LCD_DATA stay constant from SETUP until the next acceptance, so they never
//    change while E=1 or during HOLD.
//  - Counters: one down-counter sized for max(parameters). Loaded on state entry;
//    the state exits when the counter reaches 1. No wrap-around is possible.
//  - Back-to-back: when valid is held across completion, the next byte is accepted on the
//    first IDLE edge. Exactly one E pulse is issued per accepted byte.
// TESTING
//  1 Reset pulse, no writes -> four E pulses (2 cycles high each) with RS=0 and DATA
//    0x38, 0x0C, 0x01, 0x06; wait after 0x01 is 16 cycles, others 4; then init_done=1 and wr_ready=1.
//  2 After init, write rs=1 data=0x48 -> one E pulse with RS=1 and DATA=0x48 stable
//    throughout; wr_ready low for exactly 8 cycles.
//  3 After init, write rs=0 data=0x01 -> wr_ready low for 20 cycles. Write rs=0 data=0x80
//    -> wr_ready low for 8 cycles.
//  4 Hold wr_valid high with 0x41 then 0x42 (switched on acceptance) -> exactly two E pulses,
//    in order, no gap beyond the 8-cycle period, no duplicate.
//  5 Assert resetn=0 while LCD_E=1 -> LCD_E goes 0 before the next clk edge and all outputs
//    take reset values. After release, the full init sequence from test 1 is replayed.
//  6 Hold wr_valid=1 (rs=1, data=0x5A) from reset -> no acceptance until init_done.
//    Accepted on the first IDLE edge; one pulse with DATA=0x5A.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style write-only character LCD controller, 8-bit bus.
// Replays a four-command init, then strobes host bytes with cycle-counted timing.
module lcd_ctrl #(
    parameter int SETUP_CYC      = 1,
    parameter int E_HIGH_CYC     = 2,
    parameter int HOLD_CYC       = 1,
    parameter int CMD_WAIT_CYC   = 4,
    parameter int CLEAR_WAIT_CYC = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam int M1   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int M2   = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
    localparam int M3   = (M2 > CMD_WAIT_CYC) ? M2 : CMD_WAIT_CYC;
    localparam int MAXC = (M3 > CLEAR_WAIT_CYC) ? M3 : CLEAR_WAIT_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_SETUP,
        S_EHI,
        S_HOLD,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic          e_q, e_n;
    logic          rs_q, rs_n;
    logic [7:0]    data_q, data_n;
    logic          rdy_q, rdy_n;
    logic          done_q, done_n;
    logic          last;
    logic          slow_cmd;

    function automatic logic [7:0] rom(input logic [1:0] i);
        logic [7:0] r;
        unique case (i)
            2'd0: r = 8'h38;
            2'd1: r = 8'h0C;
            2'd2: r = 8'h01;
            2'd3: r = 8'h06;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign last = (cnt == CW'(1));

    // Clear/home commands (0x01..0x03) need the long execution wait
    assign slow_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q != 8'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        e_n     = e_q;
        rs_n    = rs_q;
        data_n  = data_q;
        rdy_n   = rdy_q;
        done_n  = done_q;
        unique case (state)
            S_INIT: begin
                rs_n    = 1'b0;
                data_n  = rom(idx);
                cnt_n   = CW'(SETUP_CYC);
                state_n = S_SETUP;
            end
            S_SETUP: begin
                if (last) begin
                    e_n     = 1'b1;
                    cnt_n   = CW'(E_HIGH_CYC);
                    state_n = S_EHI;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_EHI: begin
                if (last) begin
                    e_n     = 1'b0;
                    cnt_n   = CW'(HOLD_CYC);
                    state_n = S_HOLD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (last) begin
                    cnt_n   = slow_cmd ? CW'(CLEAR_WAIT_CYC)
                                       : CW'(CMD_WAIT_CYC);
                    state_n = S_WAIT;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_WAIT: begin
                if (last) begin
                    if (idx != 2'd3 && !done_q) begin
                        idx_n   = idx + 2'd1;
                        state_n = S_INIT;
                    end else begin
                        rdy_n   = 1'b1;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_IDLE: begin
                if (wr_valid) begin
                    rs_n    = wr_rs;
                    data_n  = wr_data;
                    rdy_n   = 1'b0;
                    cnt_n   = CW'(SETUP_CYC);
                    state_n = S_SETUP;
                end
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_INIT;
            cnt    <= '0;
            idx    <= 2'd0;
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            e_q    <= e_n;
            rs_q   <= rs_n;
            data_q <= data_n;
            rdy_q  <= rdy_n;
            done_q <= done_n;
        end
    end

    assign wr_ready  = rdy_q;
    assign init_done = done_q;
    assign LCD_E     = e_q;
    assign LCD_RS    = rs_q;
    assign LCD_RW    = 1'b0;
    assign LCD_DATA  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected E pulses queued at drive time,
// popped by a bus monitor on each falling E.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic       init_done;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    lcd_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .init_done (init_done),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         gap;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int hi = 0;
    int gap = 0;
    bit inp = 1'b0;
    logic       cap_rs;
    logic [7:0] cap_d;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_init();
        q.push_back('{1'b0, 8'h38, 0});
        q.push_back('{1'b0, 8'h0C, 7});
        q.push_back('{1'b0, 8'h01, 7});
        q.push_back('{1'b0, 8'h06, 19});
    endtask

    // Bus monitor: measures each E pulse and retires one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!resetn) begin
            inp = 1'b0;
        end else begin
            chk("ready_before_done", {31'd0, wr_ready & ~init_done}, 0);
            if (LCD_E && !inp) begin
                inp    = 1'b1;
                hi     = 1;
                cap_rs = LCD_RS;
                cap_d  = LCD_DATA;
                gap    = cyc - last_fall;
            end else if (LCD_E) begin
                hi++;
                chk("rs_stable_e", {31'd0, LCD_RS}, {31'd0, cap_rs});
                chk("data_stable_e", {24'd0, LCD_DATA}, {24'd0, cap_d});
            end else if (inp) begin
                inp       = 1'b0;
                last_fall = cyc;
                chk("rs_stable_hold", {31'd0, LCD_RS}, {31'd0, cap_rs});
                chk("data_stable_hold", {24'd0, LCD_DATA}, {24'd0, cap_d});
                chk("e_high_len", hi, 2);
                chk("pulse_expected", {31'd0, q.size() != 0}, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("pulse_rs", {31'd0, cap_rs}, {31'd0, e.rs});
                    chk("pulse_data", {24'd0, cap_d}, {24'd0, e.d});
                    if (e.gap != 0)
                        chk("pulse_gap", gap, e.gap);
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wr_ready) break;
        end
        chk("ready_wait", {31'd0, wr_ready}, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        chk("init_done", {31'd0, init_done}, 1);
        chk("ready_at_done", {31'd0, wr_ready}, 1);
    endtask

    task automatic count_busy(input int exp);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wr_ready) break;
            n++;
        end
        chk("busy_cycles", n, exp);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d,
                            input int busy);
        wait_ready();
        wr_valid = 1'b1;
        wr_rs    = rs;
        wr_data  = d;
        q.push_back('{rs, d, 0});
        @(posedge clk);
        #1 wr_valid = 1'b0;
        count_busy(busy);
    endtask

    task automatic chk_reset_outs();
        chk("rst_e", {31'd0, LCD_E}, 0);
        chk("rst_rs", {31'd0, LCD_RS}, 0);
        chk("rst_rw", {31'd0, LCD_RW}, 0);
        chk("rst_data", {24'd0, LCD_DATA}, 0);
        chk("rst_ready", {31'd0, wr_ready}, 0);
        chk("rst_done", {31'd0, init_done}, 0);
    endtask

    initial begin
        #2;
        chk_reset_outs();
        repeat (3) @(negedge clk);
        push_init();
        resetn = 1'b1;
        wait_done();
        repeat (2) @(negedge clk);
        chk("init_q_empty", q.size(), 0);

        do_write(1'b1, 8'h48, 8);
        do_write(1'b0, 8'h01, 20);
        do_write(1'b0, 8'h80, 8);

        wait_ready();
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h41;
        q.push_back('{1'b1, 8'h41, 0});
        q.push_back('{1'b1, 8'h42, 7});
        @(posedge clk);
        #1 wr_data = 8'h42;
        count_busy(8);
        @(posedge clk);
        #1 wr_valid = 1'b0;
        count_busy(8);
        repeat (2) @(negedge clk);
        chk("b2b_q_empty", q.size(), 0);

        wait_ready();
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h48;
        q.push_back('{1'b1, 8'h48, 0});
        @(posedge clk);
        #1 wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (LCD_E) break;
        end
        chk("e_high_pre_reset", {31'd0, LCD_E}, 1);
        resetn = 1'b0;
        #1;
        chk_reset_outs();
        q.delete();
        repeat (3) @(negedge clk);
        push_init();
        resetn = 1'b1;
        wait_done();
        repeat (2) @(negedge clk);
        chk("reinit_q_empty", q.size(), 0);

        @(negedge clk);
        resetn   = 1'b0;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h5A;
        push_init();
        q.push_back('{1'b1, 8'h5A, 7});
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        wait_done();
        @(posedge clk);
        #1;
        chk("held_accept", {31'd0, wr_ready}, 0);
        wr_valid = 1'b0;
        count_busy(8);
        repeat (12) @(negedge clk);
        chk("final_q_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
